// File: rtl/aibcr3_preclkdiv.sv
// Multi-channel registered clock divider with per-channel polarity and enable.
// New settings are staged in a shadow set and applied only at a full-period boundary.
module aibcr3_preclkdiv #(
    parameter int NCH   = 4,
    parameter int CH_W  = 2,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_ratio,
    input  logic             cfg_inv,
    input  logic             cfg_en,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   run
);

    localparam logic [DIV_W-1:0] RATIO_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] RATIO_ZERO = '0;

    logic [NCH-1:0][DIV_W-1:0] r_act_ratio;
    logic [NCH-1:0][DIV_W-1:0] r_sh_ratio;
    logic [NCH-1:0][DIV_W-1:0] r_cnt;
    logic [NCH-1:0]            r_act_inv;
    logic [NCH-1:0]            r_act_en;
    logic [NCH-1:0]            r_sh_inv;
    logic [NCH-1:0]            r_sh_en;
    logic [NCH-1:0]            r_pend;
    logic [NCH-1:0]            r_phase;
    logic [NCH-1:0]            r_clk_out;

    logic [NCH-1:0]            w_sel;
    logic [NCH-1:0]            w_accept;
    logic [NCH-1:0]            w_last;
    logic [NCH-1:0]            w_apply;
    logic                      w_cfg_ready;
    logic [DIV_W-1:0]          w_cfg_ratio;

    // A channel number beyond NCH matches no channel, so it is always ready and never loads anything.
    always_comb begin
        w_sel       = '0;
        w_last      = '0;
        w_apply     = '0;
        w_cfg_ready = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            w_sel[i]   = (cfg_ch == i[CH_W-1:0]);
            if (w_sel[i] && r_pend[i]) begin
                w_cfg_ready = 1'b0;
            end
            w_last[i]  = (r_cnt[i] == (r_act_ratio[i] - RATIO_ONE));
            w_apply[i] = r_pend[i] && (!r_act_en[i] || (w_last[i] && r_phase[i]));
        end
        w_accept = w_sel & {NCH{cfg_valid & w_cfg_ready}};
    end

    assign w_cfg_ratio = (cfg_ratio == RATIO_ZERO) ? RATIO_ONE : cfg_ratio;

    // Accept and apply never coincide for a channel: accept needs pend low, apply needs it high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_ratio <= {NCH{RATIO_ONE}};
            r_sh_ratio  <= '0;
            r_cnt       <= '0;
            r_act_inv   <= '0;
            r_act_en    <= '0;
            r_sh_inv    <= '0;
            r_sh_en     <= '0;
            r_pend      <= '0;
            r_phase     <= '0;
            r_clk_out   <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (w_accept[i]) begin
                    r_sh_ratio[i] <= w_cfg_ratio;
                    r_sh_inv[i]   <= cfg_inv;
                    r_sh_en[i]    <= cfg_en;
                    r_pend[i]     <= 1'b1;
                end
                if (w_apply[i]) begin
                    r_act_ratio[i] <= r_sh_ratio[i];
                    r_act_inv[i]   <= r_sh_inv[i];
                    r_act_en[i]    <= r_sh_en[i];
                    r_pend[i]      <= 1'b0;
                    r_cnt[i]       <= '0;
                    r_phase[i]     <= 1'b0;
                end else if (r_act_en[i]) begin
                    if (w_last[i]) begin
                        r_cnt[i]   <= '0;
                        r_phase[i] <= ~r_phase[i];
                    end else begin
                        r_cnt[i]   <= r_cnt[i] + RATIO_ONE;
                    end
                end else begin
                    r_cnt[i]   <= '0;
                    r_phase[i] <= 1'b0;
                end
                r_clk_out[i] <= r_phase[i] ^ r_act_inv[i];
            end
        end
    end

    assign cfg_ready = w_cfg_ready;
    assign clk_out   = r_clk_out;
    assign run       = r_act_en;

endmodule
